bitstream_packer: RTL

- Encoder-side writer of the 32-bit encoded bitstream RAM that the decode path reads back.
- Accepts variable-length Huffman/amplitude codes (DC, AC, zero-run, EOB) from the entropy encoder and packs them MSB-first into 32-bit words.
- Writes each word to sequential RAM addresses starting at 0; an explicit flush emits the final word padded with 1s.

---
 rtl/bitstream_packer_pkg.sv | 17 +
 rtl/bitstream_packer_if.sv | 28 ++
 rtl/bitstream_packer_code_inserter.sv | 26 ++
 rtl/bitstream_packer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/bitstream_packer_pkg.sv
// Shared definitions for the encoder-side bitstream packer and its decode-side consumers.
package bitstream_packer_pkg;

  localparam int unsigned WordW           = 32;
  localparam int unsigned MaxWordsDefault = 2406;

  // End-of-stream padding word; the decoder matches the same pattern.
  localparam logic [WordW-1:0] PadOnes = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/bitstream_packer_if.sv
// Code handshake from the entropy encoder plus the write port into the encoded bitstream RAM.
interface bitstream_packer_if #(
  parameter int unsigned CODE_W = 16,
  parameter int unsigned A      = 13
);
  import bitstream_packer_pkg::*;

  logic              code_valid_i;
  logic [CODE_W-1:0] code_i;
  logic [4:0]        code_len_i;
  logic              flush_i;
  logic              code_ready_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [A-1:0]      ram_addr_o;
  logic [WordW-1:0]  ram_data_o;

  modport master (
    output code_valid_i, code_i, code_len_i, flush_i,
    input  code_ready_o, ram_en_o, ram_we_o, ram_addr_o, ram_data_o
  );

  modport slave (
    input  code_valid_i, code_i, code_len_i, flush_i,
    output code_ready_o, ram_en_o, ram_we_o, ram_addr_o, ram_data_o
  );

endinterface

// File: rtl/bitstream_packer_code_inserter.sv
// Drops a right-aligned code of len_i bits into the accumulator directly below its fill_i
// already-used MSBs.
module bitstream_packer_code_inserter #(
  parameter int unsigned AccW   = 64,
  parameter int unsigned CODE_W = 16
) (
  input  logic [AccW-1:0]   acc_i,
  input  logic [6:0]        fill_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic [4:0]        len_i,
  output logic [AccW-1:0]   acc_o
);

  logic [AccW-1:0] mask;
  logic [AccW-1:0] code_ext;
  logic [7:0]      shamt;

  always_comb begin
    mask     = (AccW'(1) << len_i) - AccW'(1);
    code_ext = AccW'(code_i) & mask;
    // fill + len never exceeds AccW; len 0 at fill 0 shifts by AccW and yields zero.
    shamt    = 8'(AccW) - {1'b0, fill_i} - {3'b000, len_i};
    acc_o    = acc_i | (code_ext << shamt);
  end

endmodule

// File: rtl/bitstream_packer.sv
// Packs variable-length entropy codes MSB-first into 32-bit words written to sequential RAM rows,
// closing the stream with a 1-padded final word.
module bitstream_packer
  import bitstream_packer_pkg::*;
#(
  parameter int unsigned W         = WordW,
  parameter int unsigned CODE_W    = 16,
  parameter int unsigned A         = 13,
  parameter int unsigned MAX_WORDS = MaxWordsDefault
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  bitstream_packer_if.slave  bus,
  output logic [A:0]         word_count_o,
  output logic               done_o,
  output logic               error_o
);

  state_e         state_q, state_d;
  logic [2*W-1:0] acc_q, acc_d, acc_base;
  logic [6:0]     fill_q, fill_d, fill_base;
  logic [A:0]     word_count_q, word_count_d;
  logic           flush_pend_q, flush_pend_d;
  logic           done_q, done_d;
  logic           error_q, error_d;

  logic           code_ready, accept, len_ok, at_limit;
  logic           emit_req, emit, pad_req, pad_wr, write;
  logic [4:0]     ins_len;
  logic [W-1:0]   wr_data;

  always_comb begin
    code_ready = en_i && (state_q == StPack) && (fill_q <= 7'd48) && !error_q && !flush_pend_q;
    accept     = code_ready && bus.code_valid_i;
    len_ok     = bus.code_len_i <= 5'(CODE_W);
    at_limit   = word_count_q == (A+1)'(MAX_WORDS);
    emit_req   = en_i && (state_q == StPack) && (fill_q >= 7'd32);
    emit       = emit_req && !at_limit;
    pad_req    = en_i && (state_q == StFlush) && (fill_q != 7'd0);
    pad_wr     = pad_req && !at_limit;
    write      = emit || pad_wr;
    ins_len    = (accept && len_ok) ? bus.code_len_i : 5'd0;
    // The word leaving this cycle is shifted out before the new code lands behind the remainder.
    acc_base   = emit ? {acc_q[W-1:0], {W{1'b0}}} : acc_q;
    fill_base  = emit ? (fill_q - 7'd32) : fill_q;
    wr_data    = '0;
    if (emit) begin
      wr_data = acc_q[2*W-1:W];
    end else if (pad_wr) begin
      wr_data = acc_q[2*W-1:W] | (PadOnes >> fill_q);
    end
  end

  bitstream_packer_code_inserter #(
    .AccW   (2*W),
    .CODE_W (CODE_W)
  ) u_code_inserter (
    .acc_i  (acc_base),
    .fill_i (fill_base),
    .code_i (bus.code_i),
    .len_i  (ins_len),
    .acc_o  (acc_d)
  );

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    done_d       = done_q;
    error_d      = error_q;
    fill_d       = fill_base + 7'(ins_len);
    word_count_d = word_count_q + (A+1)'(write);
    if (en_i) begin
      if (bus.flush_i) flush_pend_d = 1'b1;
      if (accept && !len_ok) error_d = 1'b1;
      if (emit_req && at_limit) error_d = 1'b1;
      unique case (state_q)
        StIdle:  state_d = StPack;
        StPack: begin
          if (flush_pend_q && (fill_q < 7'd32) && !accept) state_d = StFlush;
        end
        StFlush: begin
          if (pad_req && at_limit) error_d = 1'b1;
          done_d  = 1'b1;
          state_d = StDone;
        end
        StDone:  state_d = StDone;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      fill_q       <= '0;
      word_count_q <= '0;
      flush_pend_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      word_count_q <= word_count_d;
      flush_pend_q <= flush_pend_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.code_ready_o = code_ready;
  assign bus.ram_en_o     = write;
  assign bus.ram_we_o     = write;
  assign bus.ram_addr_o   = word_count_q[A-1:0];
  assign bus.ram_data_o   = wr_data;
  assign word_count_o     = word_count_q;
  assign done_o           = done_q;
  assign error_o          = error_q;

endmodule
